// File: rtl/data_mem_ctrl_if.sv
// Request/response/watch bundle for data_mem_ctrl; master = MEM-stage requester, slave = memory.
interface data_mem_ctrl_if #(
    parameter int ADDR_WIDTH = 12
);
    logic                  reqValid;
    logic                  reqReady;
    logic                  reqWrite;
    logic [2:0]            reqFunc3;
    logic [ADDR_WIDTH-1:0] reqAddr;
    logic [31:0]           reqWdata;
    logic                  rspValid;
    logic [31:0]           rspRdata;
    logic                  rspErr;
    logic [ADDR_WIDTH-1:0] watchAddr;
    logic [31:0]           watchData;

    modport master (
        output reqValid, reqWrite, reqFunc3, reqAddr, reqWdata, watchAddr,
        input  reqReady, rspValid, rspRdata, rspErr, watchData
    );

    modport slave (
        input  reqValid, reqWrite, reqFunc3, reqAddr, reqWdata, watchAddr,
        output reqReady, rspValid, rspRdata, rspErr, watchData
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// RISC-V MEM-stage data RAM (byte/half/word, signed/unsigned loads); DATA_MEM_MISALIGNED_SPLIT_EN enables two-beat crossing accesses.
// Latency: 1 cycle response, 2 cycles for a split crossing access; watch port 1 cycle.
// Backpressure: reqReady is low only in reset and during the second beat of a split access.
module data_mem_ctrl #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic            clk,
    input  logic            rstn,
    data_mem_ctrl_if.slave  bus
);

    generate
        if (DATA_WIDTH != 32) begin : g_bad_width
            $error("data_mem_ctrl: DATA_WIDTH must be 32");
        end
    endgenerate

    localparam int WW    = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << WW;

    typedef logic [WW-1:0] widx_t;

    logic [31:0] mem [DEPTH];

    // ---------------- request decode ----------------
    logic [1:0] req_off;
    widx_t      req_w;
    logic [4:0] req_sh;
    logic       legal;
    logic [3:0] size_mask;
    logic [7:0] be8;
    logic       crossing;
    logic       accept;
    logic       req_err;

    always_comb begin
        req_off = bus.reqAddr[1:0];
        req_w   = bus.reqAddr[ADDR_WIDTH-1:2];
        req_sh  = {req_off, 3'b000};
        case (bus.reqFunc3)
            3'd0, 3'd1, 3'd2: legal = 1'b1;
            3'd4, 3'd5:       legal = !bus.reqWrite;
            default:          legal = 1'b0;
        endcase
        case (bus.reqFunc3[1:0])
            2'd0:    size_mask = 4'b0001;
            2'd1:    size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
        // Lanes 4..7 of the shifted mask belong to word w+1.
        be8      = {4'b0000, size_mask} << req_off;
        crossing = |be8[7:4];
    end

    assign accept = bus.reqValid && bus.reqReady;

`ifdef DATA_MEM_MISALIGNED_SPLIT_EN
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SPLIT = 1'b1;

    typedef struct packed {
        logic        write;
        logic [2:0]  func3;
        logic [1:0]  off;
        widx_t       w1;
        logic [3:0]  be_hi;
        logic [31:0] dat_hi;
        logic [31:0] lo;
    } split_ctx_t;

    logic [0:0] state;
    split_ctx_t ctx;
    logic       in_split;
    logic [31:0] wdata_lo;
    logic [31:0] wdata_hi;

    assign in_split           = (state == S_SPLIT);
    assign bus.reqReady       = rstn && !in_split;
    assign req_err            = !legal;
    assign {wdata_hi, wdata_lo} = {32'b0, bus.reqWdata} << req_sh;
`else
    logic [31:0] wdata_lo;

    assign bus.reqReady = rstn;
    assign req_err      = !legal || crossing;
    assign wdata_lo     = bus.reqWdata << req_sh;
`endif

    // ---------------- single write port ----------------
    logic        wr_en;
    widx_t       wr_idx;
    logic [3:0]  wr_be;
    logic [31:0] wr_dat;

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        wr_be  = '0;
        wr_dat = '0;
        if (accept && bus.reqWrite && !req_err) begin
            wr_en  = 1'b1;
            wr_idx = req_w;
            wr_be  = be8[3:0];
            wr_dat = wdata_lo;
        end
`ifdef DATA_MEM_MISALIGNED_SPLIT_EN
        if (in_split && ctx.write) begin
            wr_en  = 1'b1;
            wr_idx = ctx.w1;
            wr_be  = ctx.be_hi;
            wr_dat = ctx.dat_hi;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < 4; k++) begin
                if (wr_be[k]) mem[wr_idx][8*k +: 8] <= wr_dat[8*k +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        case (f3)
            3'd0:    extend = {{24{raw[7]}}, raw[7:0]};
            3'd1:    extend = {{16{raw[15]}}, raw[15:0]};
            3'd4:    extend = {24'b0, raw[7:0]};
            3'd5:    extend = {16'b0, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

    widx_t       rd_idx;
    logic [1:0]  ld_off;
    logic [2:0]  ld_f3;
    logic [31:0] rd_word;
    logic [31:0] lo_word;
    logic [31:0] hi_word;
    logic [31:0] raw;
    logic [31:0] load_dat;

    always_comb begin
        rd_idx = req_w;
        ld_off = req_off;
        ld_f3  = bus.reqFunc3;
`ifdef DATA_MEM_MISALIGNED_SPLIT_EN
        if (in_split) begin
            rd_idx = ctx.w1;
            ld_off = ctx.off;
            ld_f3  = ctx.func3;
        end
`endif
    end

    assign rd_word = mem[rd_idx];

    // Second beat merges the held upper bytes of word w with the fresh word w+1.
    always_comb begin
        lo_word = rd_word;
        hi_word = '0;
`ifdef DATA_MEM_MISALIGNED_SPLIT_EN
        if (in_split) begin
            lo_word = ctx.lo;
            hi_word = rd_word;
        end
`endif
    end

    assign raw      = 32'({hi_word, lo_word} >> {ld_off, 3'b000});
    assign load_dat = extend(raw, ld_f3);

    // ---------------- watch port (sees same-edge writes) ----------------
    widx_t       watch_w;
    logic [31:0] watch_cur;
    logic [31:0] watch_nxt;

    assign watch_w   = bus.watchAddr[ADDR_WIDTH-1:2];
    assign watch_cur = mem[watch_w];

    always_comb begin
        watch_nxt = watch_cur;
        for (int k = 0; k < 4; k++) begin
            if (wr_en && (wr_idx == watch_w) && wr_be[k]) watch_nxt[8*k +: 8] = wr_dat[8*k +: 8];
        end
    end

    // ---------------- response / state ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bus.rspValid  <= 1'b0;
            bus.rspErr    <= 1'b0;
            bus.rspRdata  <= '0;
            bus.watchData <= '0;
`ifdef DATA_MEM_MISALIGNED_SPLIT_EN
            state <= S_IDLE;
            ctx   <= '0;
`endif
        end else begin
            bus.watchData <= watch_nxt;
            bus.rspValid  <= 1'b0;
            bus.rspErr    <= 1'b0;
            bus.rspRdata  <= '0;
`ifdef DATA_MEM_MISALIGNED_SPLIT_EN
            if (in_split) begin
                state        <= S_IDLE;
                bus.rspValid <= 1'b1;
                bus.rspRdata <= ctx.write ? 32'b0 : load_dat;
            end else
`endif
            if (accept) begin
                if (req_err) begin
                    bus.rspValid <= 1'b1;
                    bus.rspErr   <= 1'b1;
                end
`ifdef DATA_MEM_MISALIGNED_SPLIT_EN
                else if (crossing) begin
                    state      <= S_SPLIT;
                    ctx.write  <= bus.reqWrite;
                    ctx.func3  <= bus.reqFunc3;
                    ctx.off    <= req_off;
                    ctx.w1     <= req_w + widx_t'(1);
                    ctx.be_hi  <= be8[7:4];
                    ctx.dat_hi <= wdata_hi;
                    ctx.lo     <= rd_word;
                end
`endif
                else begin
                    bus.rspValid <= 1'b1;
                    bus.rspRdata <= bus.reqWrite ? 32'b0 : load_dat;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: vector table for single-beat accesses plus hand sequences for crossing, wrap and reset cases.
module tb_data_mem_ctrl;

    localparam int AW = 12;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

    data_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        logic [31:0] watch;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];
    vec_t b2b  [3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d);
        bus.reqValid = 1'b1;
        bus.reqWrite = w;
        bus.reqFunc3 = f3;
        bus.reqAddr  = a;
        bus.reqWdata = d;
    endtask

    task automatic idle_req();
        bus.reqValid = 1'b0;
        bus.reqWrite = 1'b0;
        bus.reqFunc3 = 3'd0;
        bus.reqAddr  = '0;
        bus.reqWdata = '0;
    endtask

    // Leaves time at acceptance edge + 1.
    task automatic send(input logic w, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] d);
        drive(w, f3, a, d);
        tick();
        idle_req();
    endtask

    task automatic chk_rsp(input string name, input logic v, input logic e, input logic [31:0] d);
        chk({name, ".vld"}, 32'(bus.rspValid), 32'(v));
        chk({name, ".err"}, 32'(bus.rspErr), 32'(e));
        chk({name, ".rdata"}, bus.rspRdata, d);
    endtask

    task automatic load_chk(input string name, input logic [2:0] f3, input logic [11:0] a, input logic [31:0] exp);
        send(1'b0, f3, a, 32'h0);
        chk_rsp(name, 1'b1, 1'b0, exp);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        //            wr    f3    addr     wdata          err   rdata          watch(0x010)
        vecs[0]  = '{1'b1, 3'd2, 12'h010, 32'h8081_8283, 1'b0, 32'h0000_0000, 32'h8081_8283};
        vecs[1]  = '{1'b0, 3'd0, 12'h011, 32'h0,         1'b0, 32'hFFFF_FF82, 32'h8081_8283};
        vecs[2]  = '{1'b0, 3'd4, 12'h011, 32'h0,         1'b0, 32'h0000_0082, 32'h8081_8283};
        vecs[3]  = '{1'b0, 3'd1, 12'h012, 32'h0,         1'b0, 32'hFFFF_8081, 32'h8081_8283};
        vecs[4]  = '{1'b0, 3'd5, 12'h012, 32'h0,         1'b0, 32'h0000_8081, 32'h8081_8283};
        vecs[5]  = '{1'b0, 3'd2, 12'h010, 32'h0,         1'b0, 32'h8081_8283, 32'h8081_8283};
        vecs[6]  = '{1'b0, 3'd0, 12'h013, 32'h0,         1'b0, 32'hFFFF_FF80, 32'h8081_8283};
        vecs[7]  = '{1'b0, 3'd4, 12'h010, 32'h0,         1'b0, 32'h0000_0083, 32'h8081_8283};
        vecs[8]  = '{1'b0, 3'd1, 12'h010, 32'h0,         1'b0, 32'hFFFF_8283, 32'h8081_8283};
        vecs[9]  = '{1'b1, 3'd2, 12'h030, 32'h1122_3344, 1'b0, 32'h0000_0000, 32'h8081_8283};
        vecs[10] = '{1'b0, 3'd1, 12'h031, 32'h0,         1'b0, 32'h0000_2233, 32'h8081_8283};
        vecs[11] = '{1'b0, 3'd3, 12'h010, 32'h0,         1'b1, 32'h0000_0000, 32'h8081_8283};
        vecs[12] = '{1'b1, 3'd4, 12'h010, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8081_8283};
        vecs[13] = '{1'b0, 3'd7, 12'h010, 32'h0,         1'b1, 32'h0000_0000, 32'h8081_8283};
        vecs[14] = '{1'b1, 3'd5, 12'h010, 32'h0000_FFFF, 1'b1, 32'h0000_0000, 32'h8081_8283};
        vecs[15] = '{1'b0, 3'd2, 12'h010, 32'h0,         1'b0, 32'h8081_8283, 32'h8081_8283};

        //            wr    f3    addr     wdata          err   rdata          watch(0x020)
        b2b[0]   = '{1'b1, 3'd0, 12'h020, 32'h0000_00AA, 1'b0, 32'h0000_0000, 32'h5566_77AA};
        b2b[1]   = '{1'b1, 3'd1, 12'h022, 32'h0000_1234, 1'b0, 32'h0000_0000, 32'h1234_77AA};
        b2b[2]   = '{1'b0, 3'd2, 12'h020, 32'h0,         1'b0, 32'h1234_77AA, 32'h1234_77AA};

        idle_req();
        bus.watchAddr = 12'h010;
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.ready", 32'(bus.reqReady), 32'd0);
        chk_rsp("reset", 1'b0, 1'b0, 32'h0);
        chk("reset.watch", bus.watchData, 32'h0);
        rstn = 1'b1;
        tick();

        // Single-beat accesses, each with a one-cycle response strobe.
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("v%0d.ready", i), 32'(bus.reqReady), 32'd1);
            send(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
            chk_rsp($sformatf("v%0d", i), 1'b1, vecs[i].err, vecs[i].rdata);
            chk($sformatf("v%0d.watch", i), bus.watchData, vecs[i].watch);
            tick();
            chk($sformatf("v%0d.strobe", i), 32'(bus.rspValid), 32'd0);
        end

        // Back-to-back sb / sh / lw with read-after-write.
        send(1'b1, 3'd2, 12'h020, 32'h5566_7788);
        bus.watchAddr = 12'h020;
        tick();
        chk("b2b.preload_watch", bus.watchData, 32'h5566_7788);
        for (int i = 0; i < 3; i++) begin
            drive(b2b[i].wr, b2b[i].f3, b2b[i].addr, b2b[i].wdata);
            chk($sformatf("b2b%0d.ready", i), 32'(bus.reqReady), 32'd1);
            tick();
            chk_rsp($sformatf("b2b%0d", i), 1'b1, b2b[i].err, b2b[i].rdata);
            chk($sformatf("b2b%0d.watch", i), bus.watchData, b2b[i].watch);
        end
        idle_req();
        tick();

        // Word store crossing into the next word.
        send(1'b1, 3'd2, 12'h024, 32'h0102_0304);
        tick();
        drive(1'b1, 3'd2, 12'h023, 32'hDEAD_BEEF);
        chk("xsw.ready_before", 32'(bus.reqReady), 32'd1);
        tick();
        idle_req();
`ifdef DATA_MEM_MISALIGNED_SPLIT_EN
        chk_rsp("xsw.beat1", 1'b0, 1'b0, 32'h0);
        chk("xsw.ready_split", 32'(bus.reqReady), 32'd0);
        tick();
        chk_rsp("xsw.beat2", 1'b1, 1'b0, 32'h0);
        chk("xsw.ready_after", 32'(bus.reqReady), 32'd1);
        tick();
        chk("xsw.strobe", 32'(bus.rspValid), 32'd0);
        load_chk("xsw.w020", 3'd2, 12'h020, 32'hEF34_77AA);
        load_chk("xsw.w024", 3'd2, 12'h024, 32'h01DE_ADBE);
        send(1'b0, 3'd2, 12'h023, 32'h0);
        chk("xlw.beat1", 32'(bus.rspValid), 32'd0);
        tick();
        chk_rsp("xlw", 1'b1, 1'b0, 32'hDEAD_BEEF);
        tick();
`else
        chk_rsp("xsw", 1'b1, 1'b1, 32'h0);
        chk("xsw.ready_after", 32'(bus.reqReady), 32'd1);
        tick();
        load_chk("xsw.w020", 3'd2, 12'h020, 32'h1234_77AA);
        load_chk("xsw.w024", 3'd2, 12'h024, 32'h0102_0304);
        send(1'b0, 3'd1, 12'h013, 32'h0);
        chk_rsp("xlh", 1'b1, 1'b1, 32'h0);
        tick();
`endif

        // Halfword load wrapping from the last word to word 0.
        send(1'b1, 3'd0, 12'hFFF, 32'h0000_0034);
        tick();
        send(1'b1, 3'd0, 12'h000, 32'h0000_0092);
        tick();
        send(1'b0, 3'd1, 12'hFFF, 32'h0);
`ifdef DATA_MEM_MISALIGNED_SPLIT_EN
        chk("wrap.beat1", 32'(bus.rspValid), 32'd0);
        tick();
        chk_rsp("wrap", 1'b1, 1'b0, 32'hFFFF_9234);
`else
        chk_rsp("wrap", 1'b1, 1'b1, 32'h0);
`endif
        tick();

        // Reset while the second beat of a crossing store is pending.
        send(1'b1, 3'd2, 12'h020, 32'h1111_1111);
        tick();
        send(1'b1, 3'd2, 12'h024, 32'h2222_2222);
        tick();
        send(1'b1, 3'd2, 12'h021, 32'hAABB_CCDD);
        rstn = 1'b0;
        #1;
        chk("rst.ready", 32'(bus.reqReady), 32'd0);
        chk_rsp("rst.outs", 1'b0, 1'b0, 32'h0);
        chk("rst.watch", bus.watchData, 32'h0);
        tick();
        chk("rst.no_rsp_in_reset", 32'(bus.rspValid), 32'd0);
        rstn = 1'b1;
        tick();
        chk("rst.no_rsp_after", 32'(bus.rspValid), 32'd0);
`ifdef DATA_MEM_MISALIGNED_SPLIT_EN
        load_chk("rst.w020", 3'd2, 12'h020, 32'hBBCC_DD11);
`else
        load_chk("rst.w020", 3'd2, 12'h020, 32'h1111_1111);
`endif
        load_chk("rst.w024", 3'd2, 12'h024, 32'h2222_2222);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
